// File: rtl/tpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tpu_pkg                                                          |
// | Shared types and helpers for the systolic-array operand path.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

    function automatic int STREAM_LEN(input int size);
        return 2 * size - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_feeder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_feeder_if                                                   |
// | FIFO pop port, array advance and skewed lane outputs.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface tile_feeder_if #(
    parameter int BITS = 8,
    parameter int SIZE = 2
);
    logic                                pop;
    logic                                pop_rdy;
    logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile;
    logic                                en;
    logic [SIZE-1:0][BITS-1:0]           lane_data;
    logic [SIZE-1:0]                     lane_valid;
    logic                                tile_first;
    logic                                tile_last;
    logic                                busy;

    modport master (
        output pop, lane_data, lane_valid, tile_first, tile_last, busy,
        input  pop_rdy, tile, en
    );

    modport slave (
        input  pop, lane_data, lane_valid, tile_first, tile_last, busy,
        output pop_rdy, tile, en
    );
endinterface
`default_nettype wire

// File: rtl/tile_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_feeder                                                      |
// | Streams FIFO tiles into the array as diagonally skewed lanes.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tile_feeder
    import tpu_pkg::*;
#(
    parameter int BITS = 8,
    parameter int SIZE = 2
) (
    input  logic          clk,
    input  logic          rst,
    tile_feeder_if.master fd
);

    localparam int LEN = STREAM_LEN(SIZE);
    localparam int KW  = $clog2(LEN);
    localparam int CW  = $clog2(SIZE);
    localparam logic [KW-1:0] K_LAST = KW'(LEN - 1);
    localparam logic [KW-1:0] K_PRE  = KW'(LEN - 2);

    feeder_state_t                       state_q, state_n;
    logic [KW-1:0]                       k_q, k_n;
    logic                                pf_q, pf_n;
    logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile_q;
    logic                                load;
    logic                                pop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            pf_q    <= 1'b0;
            tile_q  <= '0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            pf_q    <= pf_n;
            if (load) begin
                tile_q <= fd.tile;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        k_n     = k_q;
        pf_n    = pf_q;
        load    = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fd.pop_rdy) begin
                    pop_c   = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                k_n     = '0;
                state_n = STREAM;
            end
            STREAM: begin
                if (fd.en) begin
                    if (k_q == K_LAST) begin
                        // Prefetched tile is already on the FIFO output: swap in with no bubble.
                        if (pf_q) begin
                            load = 1'b1;
                            k_n  = '0;
                            pf_n = 1'b0;
                        end else if (fd.pop_rdy) begin
                            pop_c   = 1'b1;
                            state_n = LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        k_n = k_q + KW'(1);
                        if (k_q == K_PRE && fd.pop_rdy) begin
                            pop_c = 1'b1;
                            pf_n  = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fd.pop        = pop_c;
    assign fd.busy       = (state_q != IDLE);
    assign fd.tile_first = (state_q == STREAM) && (k_q == '0);
    assign fd.tile_last  = (state_q == STREAM) && (k_q == K_LAST);

    // Lane i carries row i, delayed i cycles: column index is k - i.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        localparam logic [KW-1:0] LO = KW'(i);
        logic          hit;
        logic [CW-1:0] col;

        assign hit = (state_q == STREAM) && (int'(k_q) >= i) && (int'(k_q) < i + SIZE);
        assign col = CW'(k_q - LO);

        assign fd.lane_valid[i] = hit;
        assign fd.lane_data[i]  = hit ? tile_q[i][col] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tile_feeder                                                   |
// | Directed self-checking bench for tile_feeder, SIZE=2, BITS=8.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_tile_feeder;

    typedef logic [1:0][1:0][7:0] tile_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy_en = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tile_t mem [16];
    int    wr = 0;
    int    rd = 0;

    tile_feeder_if #(.BITS(8), .SIZE(2)) fd ();

    tile_feeder #(.BITS(8), .SIZE(2)) dut (
        .clk (clk),
        .rst (rst),
        .fd  (fd.master)
    );

    always #5 clk = ~clk;

    // FIFO model: dout updates the cycle after an accepted pop, flushed by reset.
    assign fd.pop_rdy = rdy_en && (rd != wr);

    always @(posedge clk) begin
        if (rst) begin
            rd <= wr;
        end else if (fd.pop) begin
            fd.tile <= mem[rd];
            rd      <= rd + 1;
        end
    end

    function automatic tile_t mk(input logic [7:0] a, b, c, d);
        tile_t t;
        t[0][0] = a;
        t[0][1] = b;
        t[1][0] = c;
        t[1][1] = d;
        return t;
    endfunction

    task automatic push(input tile_t t);
        mem[wr] = t;
        wr      = wr + 1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Fields: pop, busy, tile_first, tile_last, lane_valid[1:0], lane1, lane0
    task automatic exp_cyc(input string tag, input logic p, input logic b, input logic f,
                           input logic l, input logic [1:0] v, input logic [7:0] d1,
                           input logic [7:0] d0);
        #1;
        check_eq(tag,
                 {10'd0, fd.pop, fd.busy, fd.tile_first, fd.tile_last, fd.lane_valid,
                  fd.lane_data[1], fd.lane_data[0]},
                 {10'd0, p, b, f, l, v, d1, d0});
    endtask

    initial begin
        fd.en   = 1'b1;
        fd.tile = '0;

        step(); step();
        exp_cyc("reset", 0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        rst = 1'b0;

        // Single tile
        step(); push(mk(1, 2, 3, 4));
        exp_cyc("s1_pop",   1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s1_load",  0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s1_k0",    0, 1, 1, 0, 2'b01, 8'd0, 8'd1);
        step(); exp_cyc("s1_k1",    0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); exp_cyc("s1_k2",    0, 1, 0, 1, 2'b10, 8'd4, 8'd0);
        step(); exp_cyc("s1_idle",  0, 0, 0, 0, 2'b00, 8'd0, 8'd0);

        // Two tiles preloaded, prefetch at k=1, no bubble
        step(); push(mk(1, 2, 3, 4)); push(mk(5, 6, 7, 8));
        exp_cyc("s2_pop",   1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s2_load",  0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s2_a_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd1);
        step(); exp_cyc("s2_a_k1",  1, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); exp_cyc("s2_a_k2",  0, 1, 0, 1, 2'b10, 8'd4, 8'd0);
        step(); exp_cyc("s2_b_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd5);
        step(); exp_cyc("s2_b_k1",  0, 1, 0, 0, 2'b11, 8'd7, 8'd6);
        step(); exp_cyc("s2_b_k2",  0, 1, 0, 1, 2'b10, 8'd8, 8'd0);
        step(); exp_cyc("s2_idle",  0, 0, 0, 0, 2'b00, 8'd0, 8'd0);

        // FIFO empty at k=1, data arrives at k=2: one-cycle bubble
        step(); push(mk(1, 2, 3, 4));
        exp_cyc("s3_pop",   1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s3_load",  0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s3_a_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd1);
        step(); exp_cyc("s3_a_k1",  0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); push(mk(5, 6, 7, 8));
        exp_cyc("s3_a_k2",  1, 1, 0, 1, 2'b10, 8'd4, 8'd0);
        step(); exp_cyc("s3_bubble",0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s3_b_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd5);
        step(); exp_cyc("s3_b_k1",  0, 1, 0, 0, 2'b11, 8'd7, 8'd6);
        step(); exp_cyc("s3_b_k2",  0, 1, 0, 1, 2'b10, 8'd8, 8'd0);
        step(); exp_cyc("s3_idle",  0, 0, 0, 0, 2'b00, 8'd0, 8'd0);

        // en low at k=1 (3 cycles), then low once more at k=2 with prefetch pending
        step(); push(mk(1, 2, 3, 4)); push(mk(5, 6, 7, 8));
        exp_cyc("s4_pop",   1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s4_load",  0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s4_a_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd1);
        step(); fd.en = 1'b0;
        exp_cyc("s4_hold0", 0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); exp_cyc("s4_hold1", 0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); exp_cyc("s4_hold2", 0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); fd.en = 1'b1;
        exp_cyc("s4_a_k1",  1, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); fd.en = 1'b0;
        exp_cyc("s4_hold3", 0, 1, 0, 1, 2'b10, 8'd4, 8'd0);
        step(); fd.en = 1'b1;
        exp_cyc("s4_a_k2",  0, 1, 0, 1, 2'b10, 8'd4, 8'd0);
        step(); exp_cyc("s4_b_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd5);
        step(); exp_cyc("s4_b_k1",  0, 1, 0, 0, 2'b11, 8'd7, 8'd6);
        step(); exp_cyc("s4_b_k2",  0, 1, 0, 1, 2'b10, 8'd8, 8'd0);
        step(); exp_cyc("s4_idle",  0, 0, 0, 0, 2'b00, 8'd0, 8'd0);

        // Reset mid-stream at k=1, then clean restart
        step(); push(mk(1, 2, 3, 4));
        exp_cyc("s5_pop",   1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s5_load",  0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s5_k0",    0, 1, 1, 0, 2'b01, 8'd0, 8'd1);
        step(); rst = 1'b1;
        exp_cyc("s5_k1",    0, 1, 0, 0, 2'b11, 8'd3, 8'd2);
        step(); rst = 1'b0;
        exp_cyc("s5_aborted",0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); push(mk(9, 10, 11, 12));
        exp_cyc("s5_rpop",  1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s5_rload", 0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
        step(); exp_cyc("s5_r_k0",  0, 1, 1, 0, 2'b01, 8'd0, 8'd9);
        step(); exp_cyc("s5_r_k1",  0, 1, 0, 0, 2'b11, 8'd11, 8'd10);
        step(); exp_cyc("s5_r_k2",  0, 1, 0, 1, 2'b10, 8'd12, 8'd0);
        step(); exp_cyc("s5_idle",  0, 0, 0, 0, 2'b00, 8'd0, 8'd0);

        // pop_rdy held low: never pops, never busy
        step(); rdy_en = 1'b0; push(mk(1, 2, 3, 4));
        for (int n = 0; n < 4; n++) begin
            exp_cyc("s6_norrdy", 0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
